// File: rtl/sar_avg_seq.sv
// sar_avg_seq
// Conversion sequencer and averaging stage for the 6-bit SAR controller.
// Issues periodic one-cycle start pulses to the SAR, captures each result on
// the rising edge of eoc, accumulates 2^LogN samples and presents their
// truncated mean on a valid/ready port.
//
// Ports
//   clk_i      clock, all logic on the rising edge
//   rst_i      asynchronous, active-high reset
//   en_i       enables continuous sequencing
//   period_i   idle cycles between a capture/timeout and the next start
//   eoc_i      SAR end-of-conversion level; its rising edge is the event
//   result_i   SAR result, valid in the cycle eoc_i rises
//   start_o    one-cycle start pulse to the SAR
//   avg_o      averaged result
//   valid_o    avg_o valid
//   ready_i    consumer accepts avg_o
//   overrun_o  sticky: an unaccepted average was overwritten
//   err_o      sticky: SAR conversion timeout
module sar_avg_seq #(
  parameter int Width   = 6,
  parameter int LogN    = 2,
  parameter int PeriodW = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [PeriodW-1:0] period_i,
  input  logic               eoc_i,
  input  logic [Width-1:0]   result_i,
  output logic               start_o,
  output logic [Width-1:0]   avg_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               overrun_o,
  output logic               err_o
);

  // Accumulator holds 2^LogN full-scale samples without wrapping.
  localparam int AccW    = Width + LogN;
  localparam int Timeout = 4 * Width + 8;
  localparam int ToW     = $clog2(Timeout + 1);
  localparam logic [LogN-1:0] LastCnt = '1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_EOC,
    GAP
  } state_t;

  state_t            state_q, state_d;
  logic              eoc_q;
  logic              eoc_rise;
  logic [AccW-1:0]   acc_q;
  logic [LogN-1:0]   cnt_q;
  logic [PeriodW-1:0] gap_q;
  logic [ToW-1:0]    to_q;

  logic              capture;
  logic              timeout;
  logic              to_idle;
  logic              final_sample;
  logic [AccW-1:0]   sum;

  assign eoc_rise     = eoc_i & ~eoc_q;
  assign sum          = acc_q + AccW'(result_i);
  assign final_sample = capture && (cnt_q == LastCnt);
  assign start_o      = (state_q == START);

  // Next-state and per-cycle control strobes.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves one unassigned and infers a latch.
    state_d = state_q;
    capture = 1'b0;
    timeout = 1'b0;
    to_idle = 1'b0;
    case (state_q)
      IDLE: begin
        if (en_i) state_d = START;
      end
      START: begin
        state_d = WAIT_EOC;
      end
      WAIT_EOC: begin
        // A real edge wins over a timeout landing in the same cycle.
        if (eoc_rise) begin
          capture = 1'b1;
          state_d = GAP;
        end else if (to_q == ToW'(Timeout - 1)) begin
          timeout = 1'b1;
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          if (en_i) begin
            state_d = START;
          end else begin
            state_d = IDLE;
            to_idle = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      eoc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      eoc_q   <= eoc_i;
    end
  end

  // Timeout counter runs only while waiting; gap counter is loaded with
  // period_i at capture or timeout, so mid-gap period changes wait for the
  // next load.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_q  <= '0;
      gap_q <= '0;
    end else begin
      if (state_q == START) begin
        to_q <= '0;
      end else if (state_q == WAIT_EOC) begin
        to_q <= to_q + 1'b1;
      end

      if (capture || timeout) begin
        gap_q <= period_i;
      end else if ((state_q == GAP) && (gap_q != '0)) begin
        gap_q <= gap_q - 1'b1;
      end
    end
  end

  // Accumulator and sample count. A timeout leaves both untouched; dropping
  // back to IDLE abandons any partial average.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (final_sample || to_idle) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (capture) begin
      acc_q <= sum;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Output port. A new average always loads and keeps valid_o high; it only
  // counts as an overrun when the previous one is still held unaccepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      avg_o     <= '0;
      valid_o   <= 1'b0;
      overrun_o <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      if (final_sample) begin
        avg_o   <= sum[AccW-1:LogN];
        valid_o <= 1'b1;
        if (valid_o && !ready_i) overrun_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end

      if (timeout) err_o <= 1'b1;

      // Sticky flags are released by parking the block disabled in IDLE.
      if ((state_q == IDLE) && !en_i) begin
        overrun_o <= 1'b0;
        err_o     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sar_avg_seq.sv
// tb_sar_avg_seq
// Directed bench for sar_avg_seq. A simple SAR responder answers each start
// pulse after sar_delay cycles with the next queued result (-1 = never
// answer). A timestamp-based model predicts every output on every cycle; a
// few literal expectations pin the model itself.
module tb_sar_avg_seq;

  localparam int Width      = 6;
  localparam int LogN       = 2;
  localparam int PeriodW    = 8;
  localparam int NSamp      = 1 << LogN;
  localparam int TimeoutCyc = 4 * Width + 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [PeriodW-1:0] period;
  logic               eoc;
  logic [Width-1:0]   result;
  logic               start_o;
  logic [Width-1:0]   avg_o;
  logic               valid_o;
  logic               ready;
  logic               overrun_o;
  logic               err_o;

  int n_vec = 0;
  int n_bad = 0;
  int tb_cyc = 0;
  int last_start = 0;

  int sar_q[$];
  int sar_delay = 3;

  sar_avg_seq #(
    .Width  (Width),
    .LogN   (LogN),
    .PeriodW(PeriodW)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .period_i (period),
    .eoc_i    (eoc),
    .result_i (result),
    .start_o  (start_o),
    .avg_o    (avg_o),
    .valid_o  (valid_o),
    .ready_i  (ready),
    .overrun_o(overrun_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) tb_cyc++;
  always @(negedge clk) if (start_o) last_start = tb_cyc;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, tb_cyc);
    end
  endtask

  // ---------------------------------------------------------------------
  // Model: tracks the cycle of the last start, whether a conversion window
  // is open, and the cycle at which en decides between restart and idle.
  // m_cyc is the cycle whose outputs are currently visible; inputs sampled
  // at an edge belong to cycle m_cyc-1.
  // ---------------------------------------------------------------------
  int m_cyc = 0;
  bit m_idle = 1;
  int m_start_at = -100;
  bit m_waiting = 0;
  int m_decide_at = -1;
  bit m_eoc_prev = 0;
  int m_sum = 0;
  int m_n = 0;
  bit m_valid = 0;
  int m_avg = 0;
  bit m_ovr = 0;
  bit m_err = 0;
  int mc;
  bit m_new;
  int m_newavg;
  bit m_rise;
  bit m_clr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc = 0; m_idle = 1; m_start_at = -100; m_waiting = 0; m_decide_at = -1;
      m_eoc_prev = 0; m_sum = 0; m_n = 0;
      m_valid = 0; m_avg = 0; m_ovr = 0; m_err = 0;
    end else begin
      mc = m_cyc;
      m_cyc++;
      m_rise = eoc && !m_eoc_prev;
      m_eoc_prev = eoc;
      m_new = 0;
      m_newavg = 0;
      m_clr = m_idle && !en;

      if (m_idle) begin
        if (en) begin
          m_idle = 0;
          m_start_at = m_cyc;
          m_waiting = 1;
        end
      end else if (m_waiting && mc > m_start_at) begin
        if (m_rise) begin
          if (m_n == NSamp - 1) begin
            m_new = 1;
            m_newavg = (m_sum + int'(result)) / NSamp;
            m_sum = 0;
            m_n = 0;
          end else begin
            m_sum += int'(result);
            m_n++;
          end
          m_waiting = 0;
          m_decide_at = mc + int'(period) + 1;
        end else if (mc == m_start_at + TimeoutCyc) begin
          m_err = 1;
          m_waiting = 0;
          m_decide_at = mc + int'(period) + 1;
        end
      end else if (!m_waiting && mc == m_decide_at) begin
        if (en) begin
          m_start_at = m_cyc;
          m_waiting = 1;
        end else begin
          m_idle = 1;
          m_sum = 0;
          m_n = 0;
        end
      end

      if (m_new) begin
        if (m_valid && !ready) m_ovr = 1;
        m_valid = 1;
        m_avg = m_newavg;
      end else if (m_valid && ready) begin
        m_valid = 0;
      end

      if (m_clr) begin
        m_ovr = 0;
        m_err = 0;
      end
    end
  end

  // Compare process: every cycle outside reset.
  always @(negedge clk) begin
    if (!rst) begin
      check("start_o", int'(start_o), int'(m_start_at == m_cyc));
      check("valid_o", int'(valid_o), int'(m_valid));
      check("avg_o", int'(avg_o), m_avg);
      check("overrun_o", int'(overrun_o), int'(m_ovr));
      check("err_o", int'(err_o), int'(m_err));
    end
  end

  // SAR responder: drives eoc/result shortly after each edge.
  int sar_cd = -1;
  int sar_cur = 0;
  initial begin
    eoc = 1'b0;
    result = '0;
    forever begin
      @(posedge clk);
      #2;
      eoc = 1'b0;
      if (rst) begin
        sar_cd = -1;
      end else begin
        if (start_o) begin
          sar_cd = -1;
          if (sar_q.size() > 0) begin
            sar_cur = sar_q.pop_front();
            if (sar_cur >= 0) sar_cd = sar_delay;
          end
        end else if (sar_cd > 0) begin
          sar_cd--;
        end
        if (sar_cd == 0) begin
          eoc = 1'b1;
          result = Width'(sar_cur);
          sar_cd = -1;
        end
      end
    end
  end

  // Bounded wait on a DUT/bench event; an expired bound is a failed compare.
  task automatic wait_for(input int sel, input int budget, input string what);
    bit hit = 0;
    logic prev_eoc = eoc;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (sel)
        0: hit = valid_o;
        1: hit = start_o;
        2: hit = err_o;
        3: hit = overrun_o;
        4: hit = eoc && !prev_eoc;
        5: hit = !valid_o;
        default: hit = (sar_q.size() == 0);
      endcase
      prev_eoc = eoc;
    end
    if (!hit) check({"wait_", what}, 0, 1);
  endtask

  task automatic go_idle();
    en = 1'b0;
    repeat (60) @(negedge clk);
  endtask

  int t0;

  initial begin
    rst = 1'b1;
    en = 1'b0;
    ready = 1'b1;
    period = '0;
    #1;
    check("rst_start", int'(start_o), 0);
    check("rst_avg", int'(avg_o), 0);
    check("rst_valid", int'(valid_o), 0);
    check("rst_overrun", int'(overrun_o), 0);
    check("rst_err", int'(err_o), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // A: 10,11,12,13 with ready=1 -> 11, then valid drops.
    sar_q = '{10, 11, 12, 13};
    sar_delay = 3;
    period = 8'd0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("en_to_start", int'(start_o), 1);
    @(negedge clk);
    check("start_one_cycle", int'(start_o), 0);
    wait_for(0, 100, "avg_a");
    en = 1'b0;
    check("avg_a", int'(avg_o), 11);
    @(negedge clk);
    check("valid_a_drop", int'(valid_o), 0);
    go_idle();

    // B: 63 x4 -> 63, then 0,0,0,3 -> 0.
    sar_q = '{63, 63, 63, 63, 0, 0, 0, 3};
    en = 1'b1;
    wait_for(0, 100, "avg_full");
    check("avg_full", int'(avg_o), 63);
    wait_for(5, 10, "valid_full_drop");
    wait_for(0, 100, "avg_trunc");
    en = 1'b0;
    check("avg_trunc", int'(avg_o), 0);
    go_idle();

    // C: period 5, SAR answers 14 cycles after start -> start 7 cycles after eoc.
    sar_q.delete();
    for (int i = 0; i < 8; i++) sar_q.push_back(9);
    sar_delay = 14;
    period = 8'd5;
    en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_for(4, 60, "eoc_rise");
      t0 = tb_cyc;
      wait_for(1, 20, "restart");
      check("eoc_to_start", tb_cyc - t0, 7);
      @(negedge clk);
      check("start_width", int'(start_o), 0);
    end
    go_idle();

    // D: ready=0 over two averages (20 then 40) -> overrun, newest kept.
    sar_q = '{20, 20, 20, 20, 40, 40, 40, 40};
    sar_delay = 3;
    period = 8'd0;
    ready = 1'b0;
    en = 1'b1;
    wait_for(3, 200, "overrun");
    en = 1'b0;
    check("ovr_avg", int'(avg_o), 40);
    check("ovr_valid", int'(valid_o), 1);
    check("ovr_flag", int'(overrun_o), 1);
    ready = 1'b1;
    @(negedge clk);
    check("ovr_valid_drop", int'(valid_o), 0);
    go_idle();

    // E: timeout between samples does not count: 4,4,(none),20,20 -> 12.
    sar_q = '{4, 4, -1, 20, 20};
    period = 8'd2;
    en = 1'b1;
    wait_for(2, 150, "err");
    t0 = tb_cyc;
    check("timeout_latency", t0 - last_start, TimeoutCyc + 1);
    wait_for(1, 10, "start_after_to");
    check("start_after_to", tb_cyc - t0, 3);
    wait_for(0, 100, "avg_to");
    en = 1'b0;
    check("avg_to", int'(avg_o), 12);
    go_idle();

    // F: async reset after 2 captures; partial average discarded.
    sar_q = '{7, 7, 7, 7, 50, 50};
    period = 8'd0;
    ready = 1'b0;
    en = 1'b1;
    wait_for(0, 100, "avg_pre_rst");
    check("valid_pre_rst", int'(valid_o), 1);
    wait_for(6, 100, "drain");
    repeat (8) @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", int'(valid_o), 0);
    check("arst_avg", int'(avg_o), 0);
    check("arst_start", int'(start_o), 0);
    check("arst_overrun", int'(overrun_o), 0);
    check("arst_err", int'(err_o), 0);
    repeat (2) @(negedge clk);
    sar_q = '{30, 30, 30, 30};
    ready = 1'b1;
    rst = 1'b0;
    wait_for(0, 100, "avg_post_rst");
    en = 1'b0;
    check("avg_post_rst", int'(avg_o), 30);
    go_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got %0d cycles, expected fewer", tb_cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sar_avg_seq.md
# sar_avg_seq

Conversion sequencer and averaging stage for the 6-bit SAR controller. It issues periodic `start` pulses to the SAR FSM and captures each `result` on the rising edge of `eoc`. It accumulates 2^LogN conversions and presents their truncated mean on a valid/ready output port. It sits between the SAR controller and the downstream sample consumer, with both on the same clock.

## Interface
- `Width`, 6: SAR result width.
- `LogN`, 2: log2 of the number of samples per average (4 samples).
- `PeriodW`, 8: width of the inter-conversion gap setting.
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_i`  in  1  asynchronous, active-high reset.
- `en_i`  in  1  enables continuous sequencing.
- `period_i`  in  PeriodW  idle cycles between a capture and the next start.
- `eoc_i`  in  1  SAR end-of-conversion; level input, rising edge is the event.
- `result_i`  in  Width  SAR result; valid in the cycle `eoc_i` rises.
- `start_o`  out  1  one-cycle start pulse to the SAR.
- `avg_o`  out  Width  averaged result.
- `valid_o`  out  1  `avg_o` valid.
- `ready_i`  in  1  consumer accepts `avg_o`.
- `overrun_o`  out  1  sticky: an unaccepted average was overwritten.
- `err_o`  out  1  sticky: SAR conversion timeout.

## Operation
- Reset values: state IDLE; accumulator, sample count, gap and timeout counters all 0; `eoc_q` = 0.
- Reset output values: `start_o`, `avg_o`, `valid_o`, `overrun_o`, `err_o` all 0.
- Edge detect: `eoc_rise = eoc_i & ~eoc_q`, where `eoc_q` is `eoc_i` registered.
- `eoc_rise` is acted on only in WAIT_EOC; in all other states it is ignored.
- IDLE: if `en_i` = 1, go to START.
- START: `start_o` = 1, Moore-decoded from state. Clear the timeout counter. Go to WAIT_EOC next cycle.
- WAIT_EOC, on `eoc_rise`: capture the sample, load the gap counter with `period_i`, go to GAP.
- WAIT_EOC, timeout: the counter increments each cycle. On reaching TO = 4*Width+8 (32 at Width=6), set `err_o`, discard, leave accumulator untouched, load `period_i`, go to GAP.
- GAP, gap counter = 0: go to START if `en_i` = 1, else IDLE.
- GAP, gap counter ≠ 0: decrement.
- IDLE with `en_i` = 1 also goes to START.
- `en_i` = 0 during START or WAIT_EOC does not abort. The conversion completes or times out, then GAP exits to IDLE.
- Entering IDLE clears the accumulator and sample count. `avg_o` and `valid_o` are kept.
- Accumulator is Width+LogN bits; it cannot overflow.
- On capture when count < 2^LogN−1: `acc += result_i`, `count++`.
- On capture when count = 2^LogN−1 (final sample): `avg_o <= (acc + result_i) >> LogN`, truncating. Set `valid_o`, clear acc and count.
- Output handshake: transfer occurs when `valid_o & ready_i`; `valid_o` then clears next cycle.
- A new average and a transfer in the same cycle: load the new value, `valid_o` stays 1, no overrun.
- A new average while `valid_o` = 1 and `ready_i` = 0: overwrite `avg_o` with the newest value, keep `valid_o` = 1, set `overrun_o`.
- `overrun_o` and `err_o` clear only on reset, or in any cycle where state = IDLE and `en_i` = 0.
- `period_i` is sampled only at capture or timeout; changes mid-gap take effect on the next load.

## Timing
- `en_i` rises at cycle k in IDLE: `start_o` = 1 at k+1 only.
- `eoc_rise` at cycle c: next `start_o` = 1 at cycle c+`period_i`+2. With `period_i` = 0 that is c+2.
- Final-sample `eoc_rise` at cycle c: `valid_o` and the new `avg_o` are visible at c+1.
- Timeout: `err_o` = 1 at the cycle after the 32nd WAIT_EOC cycle. `start_o` recurs `period_i`+1 cycles later.
- Asynchronous reset asserted mid-conversion: all outputs go to 0 immediately. The partial average is lost. After release the block restarts from IDLE.

## Test plan
- Samples 10, 11, 12, 13 with `ready_i` = 1 → `valid_o` high 1 cycle after the 4th `eoc_rise`, `avg_o` = 11 (46>>2), then `valid_o` = 0.
- Four samples of 63 → `avg_o` = 63, accumulator peak 252, no wrap. Four samples of 0, 0, 0, 3 → `avg_o` = 0.
- `period_i` = 5, SAR model returning `eoc` 14 cycles after start → `start_o` pulses exactly 7 cycles after each `eoc_i` rise, each exactly 1 cycle wide.
- `ready_i` = 0 over two averages (20, then 40) → `overrun_o` = 1, `avg_o` = 40, `valid_o` held. `ready_i` = 1 → `valid_o` drops next cycle.
- SAR model never raises `eoc_i` → `err_o` = 1 after 32 WAIT_EOC cycles, a new `start_o` follows, accumulator count unchanged.
- `rst_i` pulsed after 2 of 4 captures → all outputs 0 asynchronously. After release with `en_i` = 1, the next average needs 4 fresh samples (30×4 → 30).
